// File: rtl/complete_queue_pkg.sv
// Shared types and default sizing for the completion queue between the
// functional units and the ROB.
package complete_queue_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int ADDR_W    = 32;
  localparam int CQ_IN     = 3;
  localparam int CQ_OUT    = 2;
  localparam int CQ_DEPTH  = 8;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 mispredict;
    logic                 branch_valid;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    branch_target;
  } complete_entry_t;

  // The ROB only sees branch information when the producing FU flagged it valid
  function automatic logic [ADDR_W-1:0] branch_target_of(complete_entry_t e);
    return e.branch_valid ? e.branch_target : '0;
  endfunction

endpackage

// File: rtl/complete_queue_if.sv
// Producer-side completion lanes and ROB update ports of the completion queue.
interface complete_queue_if #(
  parameter int N_IN      = complete_queue_pkg::CQ_IN,
  parameter int N_OUT     = complete_queue_pkg::CQ_OUT,
  parameter int ROB_IDX_W = complete_queue_pkg::ROB_IDX_W,
  parameter int ADDR_W    = complete_queue_pkg::ADDR_W
) ();

  logic [N_IN-1:0]                 in_valid;
  logic [N_IN-1:0][ROB_IDX_W-1:0]  in_rob_idx;
  logic [N_IN-1:0]                 in_mispredict;
  logic [N_IN-1:0]                 in_branch_valid;
  logic [N_IN-1:0]                 in_branch_taken;
  logic [N_IN-1:0][ADDR_W-1:0]     in_branch_target;
  logic                            in_ready;

  logic [N_OUT-1:0]                rob_valid;
  logic [N_OUT-1:0][ROB_IDX_W-1:0] rob_idx;
  logic [N_OUT-1:0]                rob_mispredict;
  logic [N_OUT-1:0]                rob_branch_taken;
  logic [N_OUT-1:0][ADDR_W-1:0]    rob_branch_target;

  modport master (
    output in_valid, in_rob_idx, in_mispredict, in_branch_valid,
           in_branch_taken, in_branch_target,
    input  in_ready, rob_valid, rob_idx, rob_mispredict,
           rob_branch_taken, rob_branch_target
  );

  modport slave (
    input  in_valid, in_rob_idx, in_mispredict, in_branch_valid,
           in_branch_taken, in_branch_target,
    output in_ready, rob_valid, rob_idx, rob_mispredict,
           rob_branch_taken, rob_branch_target
  );

endinterface

// File: rtl/complete_queue_compact.sv
// Combinational lane compactor: packs valid lanes to the low slots in lane
// order (lane 0 first) and reports how many there were.
module complete_queue_compact
  import complete_queue_pkg::*;
#(
  parameter int N_IN = CQ_IN,
  parameter int CNT_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0] valid,
  input  complete_entry_t lanes       [N_IN],
  output complete_entry_t out_entries [N_IN],
  output logic [CNT_W-1:0] num_valid
);

  logic [CNT_W-1:0] prefix [N_IN];

  always_comb begin
    logic [CNT_W-1:0] run;
    run = '0;
    for (int i = 0; i < N_IN; i++) begin
      prefix[i] = run;
      run = run + CNT_W'(valid[i]);
    end
    num_valid = run;
  end

  // Slot j takes the valid lane that has exactly j valid lanes below it
  always_comb begin
    for (int j = 0; j < N_IN; j++) begin
      out_entries[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (valid[i] && prefix[i] == CNT_W'(j)) out_entries[j] = lanes[i];
      end
    end
  end

endmodule

// File: rtl/complete_queue.sv
// Completion queue: compacts FU results, buffers them in age order and
// drives up to N_OUT registered ROB updates per cycle, bypassing when empty.
module complete_queue
  import complete_queue_pkg::*;
#(
  parameter int N_IN  = CQ_IN,
  parameter int N_OUT = CQ_OUT,
  parameter int DEPTH = CQ_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  complete_queue_if.slave            cq,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IN_CW = $clog2(N_IN + 1);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next;
  complete_entry_t  mem [DEPTH];

  logic             in_ready;
  logic [N_IN-1:0]  accept_valid;
  complete_entry_t  lanes       [N_IN];
  complete_entry_t  new_entries [N_IN];
  logic [IN_CW-1:0] new_cnt;

  int deq_q, take_new, enq;

  complete_entry_t  out_next [N_OUT];
  complete_entry_t  out_q    [N_OUT];
  logic [N_OUT-1:0] out_valid_next, out_valid_q;

  assign in_ready     = (count <= CNT_W'(DEPTH - N_IN));
  assign cq.in_ready  = in_ready;
  assign accept_valid = cq.in_valid & {N_IN{in_ready}};
  assign occupancy    = count;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      lanes[i] = '{rob_idx:       cq.in_rob_idx[i],
                   mispredict:    cq.in_mispredict[i],
                   branch_valid:  cq.in_branch_valid[i],
                   branch_taken:  cq.in_branch_taken[i],
                   branch_target: cq.in_branch_target[i]};
    end
  end

  complete_queue_compact #(.N_IN(N_IN), .CNT_W(IN_CW)) u_compact (
    .valid       (accept_valid),
    .lanes       (lanes),
    .out_entries (new_entries),
    .num_valid   (new_cnt)
  );

  // Buffered entries are older than this cycle's lanes, so they drain first
  always_comb begin
    deq_q      = (int'(count) < N_OUT) ? int'(count) : N_OUT;
    take_new   = (int'(new_cnt) < N_OUT - deq_q) ? int'(new_cnt) : N_OUT - deq_q;
    enq        = int'(new_cnt) - take_new;
    count_next = CNT_W'(int'(count) + enq - deq_q);
  end

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_next[k]       = '0;
      out_valid_next[k] = 1'b0;
      if (k < deq_q) begin
        out_next[k]       = mem[head + PTR_W'(k)];
        out_valid_next[k] = 1'b1;
      end
      for (int i = 0; i < N_IN; i++) begin
        if (i < take_new && k == deq_q + i) begin
          out_next[k]       = new_entries[i];
          out_valid_next[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid_q <= '0;
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid_q <= '0;
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else begin
      head        <= head + PTR_W'(deq_q);
      tail        <= tail + PTR_W'(enq);
      count       <= count_next;
      out_valid_q <= out_valid_next;
      out_q       <= out_next;
    end
  end

  // Lanes not forwarded this cycle are appended at tail in compacted order
  always_ff @(posedge clock) begin
    if (!flush) begin
      for (int i = 0; i < N_IN; i++) begin
        if (i >= take_new && i < int'(new_cnt))
          mem[tail + PTR_W'(i - take_new)] <= new_entries[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      cq.rob_valid[k]         = out_valid_q[k];
      cq.rob_idx[k]           = out_q[k].rob_idx;
      cq.rob_mispredict[k]    = out_q[k].mispredict;
      cq.rob_branch_taken[k]  = out_q[k].branch_valid & out_q[k].branch_taken;
      cq.rob_branch_target[k] = branch_target_of(out_q[k]);
    end
  end

endmodule

// File: tb/tb_complete_queue.sv
// Directed bench for complete_queue (N_IN=3, N_OUT=2, DEPTH=8): single-cycle
// bypass vectors from a table, then overflow, backpressure/wrap, flush and reset.
module tb_complete_queue;
  import complete_queue_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [3:0] occupancy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  complete_queue_if #(.N_IN(3), .N_OUT(2)) cq_if ();

  complete_queue #(.N_IN(3), .N_OUT(2), .DEPTH(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .cq        (cq_if),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] idx;
    logic [2:0]  misp;
    logic [2:0]  bv;
    logic [2:0]  bt;
    logic [95:0] tgt;
    logic [1:0]  e_valid;
    logic [9:0]  e_idx;
    logic [1:0]  e_misp;
    logic [1:0]  e_taken;
    logic [63:0] e_tgt;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [14:0] idx,
                               input logic [2:0] misp, input logic [2:0] bv,
                               input logic [2:0] bt, input logic [95:0] tgt);
    cq_if.in_valid         = valid;
    cq_if.in_rob_idx       = idx;
    cq_if.in_mispredict    = misp;
    cq_if.in_branch_valid  = bv;
    cq_if.in_branch_taken  = bt;
    cq_if.in_branch_target = tgt;
  endtask

  task automatic applyIdle();
    applyStimulus(3'b000, 15'd0, 3'b000, 3'b000, 3'b000, 96'd0);
  endtask

  task automatic applyThree(input int base);
    applyStimulus(3'b111, {5'(base + 2), 5'(base + 1), 5'(base)},
                  3'b000, 3'b000, 3'b000, 96'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 64'(cq_if.rob_valid), 64'd0);
    checkOutput({tag, "_idx"}, 64'(cq_if.rob_idx), 64'd0);
    checkOutput({tag, "_occ"}, 64'(occupancy), 64'd0);
    checkOutput({tag, "_ready"}, 64'(cq_if.in_ready), 64'd1);
  endtask

  // In-order drain check: every valid port must carry the next expected index
  task automatic checkOrder(inout int expect_next, inout int popped);
    for (int p = 0; p < 2; p++) begin
      if (cq_if.rob_valid[p]) begin
        checkOutput("order_idx", 64'(cq_if.rob_idx[p]), 64'(expect_next));
        expect_next++;
        popped++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expect_next;
    int popped;

    vecs[0] = '{3'b101, {5'd7, 5'd0, 5'd4}, 3'b000, 3'b000, 3'b000, 96'd0,
                2'b11, {5'd7, 5'd4}, 2'b00, 2'b00, 64'd0};
    vecs[1] = '{3'b001, {5'd0, 5'd0, 5'd3}, 3'b000, 3'b000, 3'b001,
                {32'd0, 32'd0, 32'hDEAD_BEEF},
                2'b01, {5'd0, 5'd3}, 2'b00, 2'b00, 64'd0};
    vecs[2] = '{3'b001, {5'd0, 5'd0, 5'd5}, 3'b000, 3'b001, 3'b001,
                {32'd0, 32'd0, 32'hDEAD_BEEF},
                2'b01, {5'd0, 5'd5}, 2'b00, 2'b01, {32'd0, 32'hDEAD_BEEF}};
    vecs[3] = '{3'b010, {5'd0, 5'd10, 5'd0}, 3'b010, 3'b000, 3'b000, 96'd0,
                2'b01, {5'd0, 5'd10}, 2'b01, 2'b00, 64'd0};
    vecs[4] = '{3'b110, {5'd13, 5'd12, 5'd0}, 3'b010, 3'b100, 3'b000,
                {32'h1234_5678, 32'd0, 32'd0},
                2'b11, {5'd13, 5'd12}, 2'b01, 2'b00, {32'h1234_5678, 32'd0}};
    vecs[5] = '{3'b000, {5'd1, 5'd2, 5'd3}, 3'b111, 3'b111, 3'b111, {96{1'b1}},
                2'b00, 10'd0, 2'b00, 2'b00, 64'd0};
    vecs[6] = '{3'b100, {5'd31, 5'd0, 5'd0}, 3'b000, 3'b100, 3'b100,
                {32'hCAFE_F00D, 32'd0, 32'd0},
                2'b01, {5'd0, 5'd31}, 2'b00, 2'b01, {32'd0, 32'hCAFE_F00D}};

    reset_n = 1'b0;
    flush   = 1'b0;
    applyIdle();
    #12;
    checkIdleOutputs("reset");
    reset_n = 1'b1;
    step();

    // Table: each vector starts from an empty queue and bypasses in one cycle
    for (int v = 0; v < 7; v++) begin
      checkOutput("tbl_ready", 64'(cq_if.in_ready), 64'd1);
      applyStimulus(vecs[v].valid, vecs[v].idx, vecs[v].misp,
                    vecs[v].bv, vecs[v].bt, vecs[v].tgt);
      step();
      checkOutput("tbl_valid", 64'(cq_if.rob_valid), 64'(vecs[v].e_valid));
      checkOutput("tbl_idx", 64'(cq_if.rob_idx), 64'(vecs[v].e_idx));
      checkOutput("tbl_misp", 64'(cq_if.rob_mispredict), 64'(vecs[v].e_misp));
      checkOutput("tbl_taken", 64'(cq_if.rob_branch_taken), 64'(vecs[v].e_taken));
      checkOutput("tbl_target", 64'(cq_if.rob_branch_target), vecs[v].e_tgt);
      checkOutput("tbl_occ", 64'(occupancy), 64'd0);
    end
    applyIdle();
    step();

    // Overflow: third lane spills into the queue and leaves one cycle later
    applyThree(1);
    step();
    checkOutput("ovf1_valid", 64'(cq_if.rob_valid), 64'b11);
    checkOutput("ovf1_idx", 64'(cq_if.rob_idx), 64'({5'd2, 5'd1}));
    checkOutput("ovf1_occ", 64'(occupancy), 64'd1);
    applyIdle();
    step();
    checkOutput("ovf2_valid", 64'(cq_if.rob_valid), 64'b01);
    checkOutput("ovf2_idx", 64'(cq_if.rob_idx), 64'({5'd0, 5'd3}));
    checkOutput("ovf2_target", 64'(cq_if.rob_branch_target), 64'd0);
    checkOutput("ovf2_occ", 64'(occupancy), 64'd0);
    step();

    // Backpressure and pointer wrap: occupancy climbs by one per cycle to 6
    expect_next = 1;
    popped      = 0;
    for (int c = 0; c < 6; c++) begin
      checkOutput("bp_ready", 64'(cq_if.in_ready), 64'd1);
      applyThree(3 * c + 1);
      step();
      checkOutput("bp_occ", 64'(occupancy), 64'(c + 1));
      checkOutput("bp_valid", 64'(cq_if.rob_valid), 64'b11);
      checkOrder(expect_next, popped);
    end
    checkOutput("bp_ready_low", 64'(cq_if.in_ready), 64'd0);
    applyThree(28);
    step();
    checkOutput("bp_ignored_occ", 64'(occupancy), 64'd4);
    checkOrder(expect_next, popped);
    applyIdle();
    for (int c = 0; c < 2; c++) begin
      step();
      checkOrder(expect_next, popped);
    end
    checkOutput("bp_drained_occ", 64'(occupancy), 64'd0);
    checkOutput("bp_total", 64'(popped), 64'd18);
    step();
    checkOutput("bp_after_valid", 64'(cq_if.rob_valid), 64'd0);

    // Flush with 5 buffered entries and 2 incoming lanes
    for (int c = 0; c < 5; c++) begin
      applyThree(3 * c + 1);
      step();
    end
    checkOutput("fl_pre_occ", 64'(occupancy), 64'd5);
    applyStimulus(3'b011, {5'd0, 5'd21, 5'd20}, 3'b000, 3'b000, 3'b000, 96'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyIdle();
    checkIdleOutputs("flush");
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("fl_quiet_valid", 64'(cq_if.rob_valid), 64'd0);
      checkOutput("fl_quiet_occ", 64'(occupancy), 64'd0);
    end

    // Asynchronous reset between edges with 4 entries buffered
    for (int c = 0; c < 4; c++) begin
      applyThree(3 * c + 1);
      step();
    end
    checkOutput("rst_pre_occ", 64'(occupancy), 64'd4);
    applyIdle();
    #2;
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("async_rst");
    #3;
    reset_n = 1'b1;
    step();
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd9}, 3'b000, 3'b000, 3'b000, 96'd0);
    step();
    checkOutput("rst_bypass_valid", 64'(cq_if.rob_valid), 64'b01);
    checkOutput("rst_bypass_idx", 64'(cq_if.rob_idx), 64'({5'd0, 5'd9}));
    checkOutput("rst_bypass_occ", 64'(occupancy), 64'd0);
    applyIdle();
    step();
    checkOutput("rst_tail_valid", 64'(cq_if.rob_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/complete_queue.md
Name: complete_queue

Overview:
- Parametrised successor to the per-lane completion stage.
- Accepts up to N_IN functional-unit results per cycle from the EX/COMP pipe register.
- Compacts the valid results, buffers them in age order in a circular queue, and drives up to N_OUT registered ROB completion updates per cycle.
- Decouples FU completion width from ROB write-port count, applies backpressure when full, and is cleared by a pipeline flush.

Parameters:
N_IN, `N, number of FU completion lanes
N_OUT, 2, number of ROB update ports per cycle (1 <= N_OUT <= DEPTH)
DEPTH, 8, queue entries; power of 2, DEPTH >= N_IN
ROB_IDX_W, 5, ROB index width
ADDR_W, 32, branch target width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear (mispredict recovery), sampled on rising edge
in_valid  in  N_IN  per-lane result valid
in_rob_idx  in  N_IN x ROB_IDX_W  per-lane ROB index
in_mispredict  in  N_IN  per-lane mispredict flag
in_branch_valid  in  N_IN  per-lane branch-info valid
in_branch_taken  in  N_IN  per-lane branch outcome
in_branch_target  in  N_IN x ADDR_W  per-lane branch target
in_ready  out  1  queue can accept a full N_IN-lane group this cycle
rob_valid  out  N_OUT  ROB update port valid
rob_idx  out  N_OUT x ROB_IDX_W  ROB index to mark complete
rob_mispredict  out  N_OUT  mispredict flag
rob_branch_taken  out  N_OUT  branch outcome
rob_branch_target  out  N_OUT x ADDR_W  branch target
occupancy  out  $clog2(DEPTH+1)  buffered entry count (registered)

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset_n low asynchronously clears head, tail, count and all output registers; every output reads 0.
  - in_ready = 1 after reset (derived from count = 0).
- Acceptance:
  - in_ready = ((DEPTH - count) >= N_IN), computed from registered count only.
  - The producer must hold lanes invalid when in_ready = 0; lanes valid while in_ready = 0 are ignored and not stored.
  - All-or-nothing: there is no per-lane ready.
- Compaction and ordering:
  - Accepted valid lanes are compacted in ascending lane order (lane 0 oldest).
  - Invalid lanes leave no hole.
  - Age order is queue order (head oldest), then this cycle's incoming lanes.
- Drain, every cycle:
  - Candidates are the buffered entries from head, then this cycle's accepted lanes.
  - The oldest min(candidates, N_OUT) are written into the output registers at the rising edge; the remainder stay or enqueue.
  - Latency is 1 cycle when the queue is empty (bypass).
  - Otherwise an entry leaves only after all older entries have left.
  - No ROB backpressure: outputs are valid for exactly one cycle.
- Output field rules:
  - Output port k is filled in age order; port k valid implies ports 0..k-1 valid.
  - Unused ports have all fields 0.
  - rob_branch_taken and rob_branch_target are 0 unless the entry's branch_valid was 1.
  - rob_mispredict is passed through unchanged.
- Pointers:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - count_next = count + enqueued - dequeued_from_queue; it never exceeds DEPTH and never underflows.
  - Full with wrap-around (head = tail, count = DEPTH) must drain correctly.
- Flush:
  - At the edge, flush = 1 clears head, tail and count, and zeroes all rob_* outputs.
  - Inputs presented in the flush cycle are dropped.
  - flush has priority over enqueue and drain.
  - flush combined with asynchronous reset: reset wins.
- Reset mid-operation: all buffered entries are lost; there is no partial output.
- Simultaneous events: enqueue and drain in the same cycle are legal; pointers are updated once from combined counts.

Decomposition:
- The shared package (sys_defs.svh) gains:
  - COMPLETE_ENTRY struct: rob_idx, mispredict, branch_valid, branch_taken, branch_target.
  - CQ_DEPTH and CQ_OUT defines.
  - ROB_UPDATE_PACKET widened to a parametrised port count.
- One sub-module is natural: cq_compact, a purely combinational lane compactor that maps the N_IN valid mask to packed entries plus a count, using a prefix-sum of in_valid.

Test Plan (N_IN=3, N_OUT=2, DEPTH=8):
- Bypass: empty queue; lanes 0,2 valid with idx 4,7 -> next cycle rob_valid=2'b11, rob_idx={7,4} (port0=4); occupancy stays 0.
- Overflow to queue: 3 lanes idx 1,2,3 -> cycle+1 ports idx 1,2; occupancy 1; cycle+2 port0 idx 3, port1 invalid with all fields 0.
- Backpressure and wrap: 3 lanes every cycle for 6 cycles -> occupancy rises by 1 per cycle; once DEPTH - count < 3, in_ready drops at count=6; ROB order strictly preserved across pointer wrap; no entry lost or duplicated.
- Branch masking: lane 0 branch_valid=0, taken=1, target=0xDEAD_BEEF -> rob_branch_taken=0, rob_branch_target=0; with branch_valid=1 -> 1 and 0xDEAD_BEEF.
- Flush: occupancy 5 plus 2 incoming lanes with flush=1 -> next cycle occupancy 0, rob_valid=0, in_ready=1; neither the incoming lanes nor the 5 buffered entries appear on any later cycle.
- Async reset mid-stream: drop reset_n between clock edges with occupancy 4 -> outputs 0 immediately; after release, first valid input bypasses with 1-cycle latency.
